// File: rtl/adam_obi_arbiter.sv
// OBI N-to-1 arbiter with request lock, in-order ID FIFO for response routing and pause handshake.
// Build option: define ADAM_OBI_ARBITER_RR_EN for round-robin arbitration (fixed priority otherwise).
module adam_obi_arbiter #(
  parameter int unsigned NO_REQS    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_TRANS  = 4,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 pause_req,
  output logic                                 pause_ack,
  input  logic [NO_REQS-1:0]                   s_req,
  output logic [NO_REQS-1:0]                   s_gnt,
  input  logic [NO_REQS-1:0][ADDR_WIDTH-1:0]   s_addr,
  input  logic [NO_REQS-1:0]                   s_we,
  input  logic [NO_REQS-1:0][STRB_WIDTH-1:0]   s_be,
  input  logic [NO_REQS-1:0][DATA_WIDTH-1:0]   s_wdata,
  output logic [NO_REQS-1:0]                   s_rvalid,
  input  logic [NO_REQS-1:0]                   s_rready,
  output logic [NO_REQS-1:0][DATA_WIDTH-1:0]   s_rdata,
  output logic                                 m_req,
  output logic [ADDR_WIDTH-1:0]                m_addr,
  output logic                                 m_we,
  output logic [STRB_WIDTH-1:0]                m_be,
  output logic [DATA_WIDTH-1:0]                m_wdata,
  input  logic                                 m_gnt,
  input  logic                                 m_rvalid,
  output logic                                 m_rready,
  input  logic [DATA_WIDTH-1:0]                m_rdata
);

  localparam int unsigned ID_W  = (NO_REQS > 1) ? $clog2(NO_REQS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_TRANS) + 1;
  localparam int unsigned PTR_W = (MAX_TRANS > 1) ? $clog2(MAX_TRANS) : 1;

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == PTR_W'(MAX_TRANS - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [CNT_W-1:0] count_q, count_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  id_t              id_fifo_q [MAX_TRANS];
  id_t              id_fifo_d [MAX_TRANS];
  logic             lock_q, lock_d;
  id_t              locked_id_q, locked_id_d;
  logic             pause_ack_q, pause_ack_d;
`ifdef ADAM_OBI_ARBITER_RR_EN
  id_t              rr_ptr_q, rr_ptr_d;
`endif

  id_t  winner;
  id_t  sel;
  id_t  head;
  logic can_issue;
  logic push;
  logic pop;
  logic cnt_nz;

  // Arbitration: pick a winner among asserted requests, overridden by a held lock.
  always_comb begin
    winner = '0;
`ifdef ADAM_OBI_ARBITER_RR_EN
    begin
      logic        found;
      int unsigned cand;
      found = 1'b0;
      cand  = 0;
      for (int unsigned k = 0; k < NO_REQS; k++) begin
        cand = 32'(rr_ptr_q) + k;
        if (cand >= NO_REQS) begin
          cand = cand - NO_REQS;
        end else begin
          cand = cand;
        end
        for (int unsigned j = 0; j < NO_REQS; j++) begin
          if (!found && (cand == j) && s_req[j]) begin
            winner = ID_W'(j);
            found  = 1'b1;
          end else begin
            found = found;
          end
        end
      end
    end
`else
    for (int i = int'(NO_REQS) - 1; i >= 0; i--) begin
      if (s_req[i]) begin
        winner = ID_W'(i);
      end else begin
        winner = winner;
      end
    end
`endif
    if (lock_q) begin
      sel = locked_id_q;
    end else begin
      sel = winner;
    end
  end

  // Address phase mux and grant steering.
  always_comb begin
    can_issue = (count_q < CNT_W'(MAX_TRANS)) && (!pause_req || lock_q) && !pause_ack_q;
    m_req     = 1'b0;
    m_addr    = '0;
    m_we      = 1'b0;
    m_be      = '0;
    m_wdata   = '0;
    for (int unsigned i = 0; i < NO_REQS; i++) begin
      if (sel == ID_W'(i)) begin
        m_req   = s_req[i] && can_issue;
        m_addr  = s_addr[i];
        m_we    = s_we[i];
        m_be    = s_be[i];
        m_wdata = s_wdata[i];
      end else begin
        m_req = m_req;
      end
    end
    push = m_req && m_gnt;
    for (int unsigned i = 0; i < NO_REQS; i++) begin
      s_gnt[i] = push && (sel == ID_W'(i));
    end
  end

  // Response routing to the requester at the FIFO head; stray responses with nothing outstanding are dropped.
  always_comb begin
    cnt_nz   = (count_q != '0);
    head     = id_fifo_q[rd_ptr_q];
    m_rready = 1'b0;
    for (int unsigned i = 0; i < NO_REQS; i++) begin
      s_rdata[i]  = m_rdata;
      s_rvalid[i] = m_rvalid && cnt_nz && (head == ID_W'(i));
      if (head == ID_W'(i)) begin
        m_rready = s_rready[i] && cnt_nz;
      end else begin
        m_rready = m_rready;
      end
    end
    pop = m_rvalid && m_rready;
  end

  // Next-state: FIFO, outstanding count, lock, pause handshake, round-robin pointer.
  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    id_fifo_d   = id_fifo_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
`ifdef ADAM_OBI_ARBITER_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    if (push) begin
      id_fifo_d[wr_ptr_q] = sel;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end

    // A stalled request is pinned so the address phase cannot change under the master.
    if (push) begin
      lock_d = 1'b0;
    end else if (m_req) begin
      lock_d      = 1'b1;
      locked_id_d = sel;
    end else begin
      lock_d = lock_q;
    end

`ifdef ADAM_OBI_ARBITER_RR_EN
    if (push) begin
      if (sel == ID_W'(NO_REQS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = sel + ID_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
`endif

    if (pause_ack_q) begin
      pause_ack_d = pause_req;
    end else begin
      pause_ack_d = pause_req && !cnt_nz && !lock_q;
    end
  end

  assign pause_ack = pause_ack_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
      pause_ack_q <= 1'b0;
      for (int unsigned i = 0; i < MAX_TRANS; i++) begin
        id_fifo_q[i] <= '0;
      end
`ifdef ADAM_OBI_ARBITER_RR_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      pause_ack_q <= pause_ack_d;
      id_fifo_q   <= id_fifo_d;
`ifdef ADAM_OBI_ARBITER_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_adam_obi_arbiter.sv
// Directed self-checking bench for adam_obi_arbiter (NO_REQS=2, MAX_TRANS=4).
module tb_adam_obi_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic              pause_req;
  logic              pause_ack;
  logic [1:0]        s_req;
  logic [1:0]        s_gnt;
  logic [1:0][31:0]  s_addr;
  logic [1:0]        s_we;
  logic [1:0][3:0]   s_be;
  logic [1:0][31:0]  s_wdata;
  logic [1:0]        s_rvalid;
  logic [1:0]        s_rready;
  logic [1:0][31:0]  s_rdata;
  logic              m_req;
  logic [31:0]       m_addr;
  logic              m_we;
  logic [3:0]        m_be;
  logic [31:0]       m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic              m_rready;
  logic [31:0]       m_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [1:0] exp_g [4];

  adam_obi_arbiter #(
    .NO_REQS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_TRANS(4)
  ) dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
    .s_req(s_req), .s_gnt(s_gnt), .s_addr(s_addr), .s_we(s_we), .s_be(s_be),
    .s_wdata(s_wdata), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
`ifdef ADAM_OBI_ARBITER_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    rst = 1'b1; pause_req = 1'b0; s_req = 2'b00; s_we = 2'b01; s_be = '1;
    s_addr[0] = 32'h0000_0300; s_addr[1] = 32'h0000_0100;
    s_wdata[0] = 32'h1111_0000; s_wdata[1] = 32'h2222_0000;
    s_rready = 2'b11; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    m_rvalid = 1'b1;
    #1;
    chk("reset_count", 64'(dut.count_q), 64'd0);
    chk("reset_gnt", 64'(s_gnt), 64'd0);
    chk("reset_mreq", 64'(m_req), 64'd0);
    chk("reset_pack", 64'(pause_ack), 64'd0);
    chk("stray_rvalid", 64'(s_rvalid), 64'd0);
    chk("stray_rready", 64'(m_rready), 64'd0);
    tick();
    chk("stray_no_pop", 64'(dut.count_q), 64'd0);

    // single read from requester 1
    m_rvalid = 1'b0; s_req = 2'b10; m_gnt = 1'b1; #1;
    chk("t1_gnt", 64'(s_gnt), 64'h2);
    chk("t1_addr", 64'(m_addr), 64'h100);
    chk("t1_wdata", 64'(m_wdata), 64'h2222_0000);
    tick();
    chk("t1_count1", 64'(dut.count_q), 64'd1);
    s_req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; s_rready = 2'b10; #1;
    chk("t1_rvalid", 64'(s_rvalid), 64'h2);
    chk("t1_rready", 64'(m_rready), 64'd1);
    chk("t1_rdata", 64'(s_rdata[1]), 64'hDEAD_BEEF);
    tick();
    chk("t1_count0", 64'(dut.count_q), 64'd0);

    // contention with streaming responses: push and pop together keep count at 1
    s_req = 2'b11; m_gnt = 1'b1; s_rready = 2'b11; m_rvalid = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_gnt%0d", k), 64'(s_gnt), 64'(exp_g[k]));
      if (k > 0) chk($sformatf("t2_rv%0d", k), 64'(s_rvalid), 64'(exp_g[k-1]));
      tick();
      chk($sformatf("t2_cnt%0d", k), 64'(dut.count_q), 64'd1);
      m_rvalid = 1'b1; #1;
    end
    s_req = 2'b00; #1;
    chk("t2_rv_last", 64'(s_rvalid), 64'(exp_g[3]));
    tick();
    chk("t2_drained", 64'(dut.count_q), 64'd0);

    // lock: requester 1 stalls, requester 0 arrives later
    m_rvalid = 1'b0; s_addr[1] = 32'h0000_0200; s_req = 2'b10; m_gnt = 1'b0; #1;
    chk("t3_addr_c1", 64'(m_addr), 64'h200);
    chk("t3_nogrant", 64'(s_gnt), 64'd0);
    tick();
    s_req = 2'b11; #1;
    chk("t3_lock", 64'(dut.lock_q), 64'd1);
    chk("t3_addr_c2", 64'(m_addr), 64'h200);
    tick(); #1;
    chk("t3_addr_c3", 64'(m_addr), 64'h200);
    m_gnt = 1'b1; #1;
    chk("t3_gnt1", 64'(s_gnt), 64'h2);
    tick();
    chk("t3_unlock", 64'(dut.lock_q), 64'd0);
    chk("t3_gnt0", 64'(s_gnt), 64'h1);
    chk("t3_addr0", 64'(m_addr), 64'h300);
    tick();
    s_req = 2'b00; m_rvalid = 1'b1; #1;
    chk("t3_rv_first", 64'(s_rvalid), 64'h2);
    tick();
    chk("t3_rv_second", 64'(s_rvalid), 64'h1);
    tick();
    m_rvalid = 1'b0;
    chk("t3_drained", 64'(dut.count_q), 64'd0);

    // fill to MAX_TRANS with IDs 0,1,0,1
    m_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_req = (k % 2 == 0) ? 2'b01 : 2'b10; #1;
      chk($sformatf("t4_gnt%0d", k), 64'(s_gnt), 64'(s_req));
      tick();
    end
    chk("t4_full", 64'(dut.count_q), 64'd4);
    s_req = 2'b11; #1;
    chk("t4_full_mreq", 64'(m_req), 64'd0);
    chk("t4_full_gnt", 64'(s_gnt), 64'd0);
    tick();
    chk("t4_still_full", 64'(dut.count_q), 64'd4);
    s_req = 2'b00; m_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t4_rv%0d", k), 64'(s_rvalid), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    m_rvalid = 1'b0;
    chk("t4_empty", 64'(dut.count_q), 64'd0);

    // pause with two outstanding
    s_req = 2'b01; tick();
    s_req = 2'b10; tick();
    chk("t5_cnt2", 64'(dut.count_q), 64'd2);
    s_req = 2'b01; pause_req = 1'b1; #1;
    chk("t5_mreq_blk", 64'(m_req), 64'd0);
    chk("t5_gnt_blk", 64'(s_gnt), 64'd0);
    tick();
    chk("t5_ack0a", 64'(pause_ack), 64'd0);
    m_rvalid = 1'b1; #1;
    chk("t5_rv0", 64'(s_rvalid), 64'h1);
    tick();
    chk("t5_ack0b", 64'(pause_ack), 64'd0);
    chk("t5_rv1", 64'(s_rvalid), 64'h2);
    tick();
    m_rvalid = 1'b0;
    chk("t5_cnt0", 64'(dut.count_q), 64'd0);
    chk("t5_ack0c", 64'(pause_ack), 64'd0);
    tick();
    chk("t5_ack1", 64'(pause_ack), 64'd1);
    chk("t5_paused_mreq", 64'(m_req), 64'd0);
    pause_req = 1'b0; #1;
    chk("t5_ackhold_mreq", 64'(m_req), 64'd0);
    tick();
    chk("t5_ack_drop", 64'(pause_ack), 64'd0);
    chk("t5_resume_gnt", 64'(s_gnt), 64'h1);
    tick();
    chk("t5_resume_cnt", 64'(dut.count_q), 64'd1);

    // reset with three outstanding and a held lock
    s_req = 2'b10; tick();
    s_req = 2'b01; tick();
    m_gnt = 1'b0; tick();
    chk("t6_cnt3", 64'(dut.count_q), 64'd3);
    chk("t6_lock", 64'(dut.lock_q), 64'd1);
    rst = 1'b1; m_rvalid = 1'b1; tick();
    rst = 1'b0; s_req = 2'b00; #1;
    chk("t6_count", 64'(dut.count_q), 64'd0);
    chk("t6_lock0", 64'(dut.lock_q), 64'd0);
    chk("t6_pack", 64'(pause_ack), 64'd0);
    chk("t6_gnt", 64'(s_gnt), 64'd0);
    chk("t6_rvalid", 64'(s_rvalid), 64'd0);
    chk("t6_mreq", 64'(m_req), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
